// File: rtl/readout_scheduler_if.sv
// Handshake bundle between the readout scheduler and the channel readout /
// event builder around it. The scheduler takes the master view.
interface readout_scheduler_if;
  logic        need_read;
  logic [15:0] ch_mask;
  logic        rd_done;
  logic        err_clr;
  logic [15:0] evt_tx;
  logic [3:0]  rd_sel;
  logic        rd_start;
  logic        hdr_wr;
  logic        trl_wr;
  logic        busy;
  logic [15:0] err_flags;

  modport master (
    input  need_read, ch_mask, rd_done, err_clr,
    output evt_tx, rd_sel, rd_start, hdr_wr, trl_wr, busy, err_flags
  );

  modport slave (
    output need_read, ch_mask, rd_done, err_clr,
    input  evt_tx, rd_sel, rd_start, hdr_wr, trl_wr, busy, err_flags
  );
endinterface

// File: rtl/readout_scheduler.sv
// Readout scheduler: walks the 16 channel buffers once per event, framing
// the readout with a header and a trailer write, and flags channels that
// fail to finish within the timeout window.
module readout_scheduler #(
  parameter int TIMEOUT_CYC = 4095,
  parameter int HOLD_CYC    = 2
) (
  input logic                 clk,
  input logic                 reset,
  readout_scheduler_if.master bus
);

  typedef enum logic [3:0] {
    IDLE,
    HEADER,
    SCAN,
    REQ,
    WAIT,
    NEXT,
    TRAILER,
    DONE,
    HOLD
  } state_t;

  // One counter serves both the WAIT timeout and the HOLD dwell, so it is
  // sized for whichever window is longer.
  localparam int MAX_CYC = (TIMEOUT_CYC > HOLD_CYC) ? TIMEOUT_CYC : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       evtTx_q, evtTx_d;
  logic [15:0]       errFlags_q, errFlags_d;

  logic tmoHit;
  logic holdLast;

  // rd_done beats the timeout when both land on the same WAIT cycle.
  assign tmoHit   = (state_q == WAIT) && !bus.rd_done && (cnt_q == TMO_LAST);
  assign holdLast = (cnt_q == HOLD_LAST);

  // State register; reset aborts any event in progress.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers: channel index, shared cycle counter, event count, error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= 4'd0;
      cnt_q      <= '0;
      evtTx_q    <= 16'd0;
      errFlags_q <= 16'd0;
    end else begin
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      evtTx_q    <= evtTx_d;
      errFlags_q <= errFlags_d;
    end
  end

  // Next-state sequencing through header, per-channel scan/read, trailer and hold.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.need_read) state_d = HEADER;
      HEADER:  state_d = SCAN;
      SCAN:    state_d = bus.ch_mask[idx_q] ? NEXT : REQ;
      REQ:     state_d = WAIT;
      WAIT:    if (bus.rd_done || (cnt_q == TMO_LAST)) state_d = NEXT;
      NEXT:    state_d = (idx_q == 4'hF) ? TRAILER : SCAN;
      TRAILER: state_d = DONE;
      DONE:    state_d = (HOLD_CYC > 0) ? HOLD : IDLE;
      HOLD:    if (holdLast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the datapath; a timeout set overrides a same-cycle clear.
  always_comb begin
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    evtTx_d    = evtTx_q;
    errFlags_d = bus.err_clr ? 16'd0 : errFlags_q;
    unique case (state_q)
      HEADER: idx_d = 4'd0;
      REQ:    cnt_d = '0;
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (tmoHit) errFlags_d[idx_q] = 1'b1;
      end
      NEXT:   if (idx_q != 4'hF) idx_d = idx_q + 4'd1;
      DONE: begin
        evtTx_d = evtTx_q + 16'd1;
        cnt_d   = '0;
      end
      HOLD:   cnt_d = cnt_q + 1'b1;
      default: ;
    endcase
  end

  // Moore outputs decoded purely from the registered state.
  always_comb begin
    bus.hdr_wr   = (state_q == HEADER);
    bus.rd_start = (state_q == REQ);
    bus.trl_wr   = (state_q == TRAILER);
    bus.busy     = (state_q != IDLE);
    bus.rd_sel   = 4'd0;
    if ((state_q == SCAN) || (state_q == REQ) || (state_q == WAIT) || (state_q == NEXT))
      bus.rd_sel = idx_q;
  end

  assign bus.evt_tx    = evtTx_q;
  assign bus.err_flags = errFlags_q;

endmodule

// File: doc/readout_scheduler.md
READOUT_SCHEDULER -- requirements
Module: readout_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYC, default 4095: maximum cycles spent waiting in WAIT for one channel's rd_done.
REQ-002 Parameter HOLD_CYC, default 2: cycles spent in HOLD after an event completes, so need_read can re-settle.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 need_read  input  1  level: at least one complete event is pending in every channel buffer.
REQ-006 ch_mask  input  16  per-channel skip; 1 = skip that channel.
REQ-007 rd_done  input  1  pulse from the channel readout: the selected channel has finished transferring its event.
REQ-008 err_clr  input  1  pulse that clears err_flags.
REQ-009 evt_tx  output  16  count of events fully read out; feeds the receive manager.
REQ-010 rd_sel  output  4  index of the channel being scanned or read.
REQ-011 rd_start  output  1  one-cycle pulse that starts readout of channel rd_sel.
REQ-012 hdr_wr  output  1  one-cycle pulse to write the event header; header data = evt_tx.
REQ-013 trl_wr  output  1  one-cycle pulse to write the event trailer.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 err_flags  output  16  sticky per-channel timeout flags.

Function
REQ-016 Moore FSM; outputs decode from the registered state.
- States: IDLE, HEADER, SCAN, REQ, WAIT, NEXT, TRAILER, DONE, HOLD.
REQ-017 IDLE: go to HEADER when need_read=1; otherwise stay in IDLE.
REQ-018 HEADER (1 cycle):
- hdr_wr=1.
- Channel index idx is set to 0.
- Next state is SCAN.
REQ-019 SCAN (1 cycle): rd_sel=idx.
- If ch_mask[idx]=1, go to NEXT.
- Otherwise go to REQ.
REQ-020 REQ (1 cycle): rd_start=1, rd_sel=idx, then WAIT.
- The timeout counter is cleared on entry.
REQ-021 WAIT: rd_sel=idx; the timeout counter increments every cycle.
- If rd_done=1, go to NEXT.
- Else if the counter equals TIMEOUT_CYC-1, set err_flags[idx] and go to NEXT.
- rd_done has priority over timeout when both occur in the same cycle.
REQ-022 NEXT (1 cycle):
- If idx=15, go to TRAILER.
- Otherwise idx=idx+1 (4-bit, no wrap past 15) and go to SCAN.
REQ-023 TRAILER (1 cycle): trl_wr=1, then DONE.
REQ-024 DONE (1 cycle): evt_tx increments by 1 (16-bit, wraps from 0xFFFF to 0x0000), then HOLD.
REQ-025 HOLD: stay exactly HOLD_CYC cycles and ignore need_read, then IDLE.
REQ-026 rd_done is ignored in every state except WAIT.
REQ-027 ch_mask is sampled only in SCAN; changing it mid-event affects only channels not yet scanned.
REQ-028 err_flags: err_clr clears all bits.
- If err_clr and a timeout set occur in the same cycle, the set wins for that bit.
REQ-029 All-masked event: HEADER, then 16 SCAN/NEXT pairs, then TRAILER; rd_start never pulses; evt_tx still increments.
REQ-030 Latency from need_read=1 in IDLE (cycle t), channel 0 unmasked:
- hdr_wr at t+1.
- SCAN at t+2.
- rd_start at t+3.
REQ-031 Minimum event time with all channels unmasked and rd_done on the first WAIT cycle: 1 + 16x4 + 1 + 1 + HOLD_CYC cycles.
REQ-032 rd_start, hdr_wr and trl_wr are never high in the same cycle.

Reset
REQ-033 Reset values: state=IDLE, idx=0, evt_tx=0, err_flags=0, timeout counter=0.
- Outputs: rd_sel=0, rd_start=0, hdr_wr=0, trl_wr=0, busy=0.
REQ-034 Reset asserted mid-event aborts immediately.
- No trl_wr is issued and evt_tx does not increment.
- The FSM is in IDLE on the cycle after reset deasserts.
REQ-035 Reset has priority over every other input, including err_clr and rd_done.

Verification
REQ-036 ch_mask=0, need_read=1 held, rd_done on the 3rd WAIT cycle of each channel:
- hdr_wr once, rd_sel steps 0..15, rd_start 16 times, trl_wr once.
- evt_tx goes 0 -> 1; busy then drops after HOLD.
REQ-037 ch_mask=0xFFFE, rd_done never asserted, TIMEOUT_CYC=8:
- Channel 0 times out after 8 WAIT cycles; err_flags=0x0001; evt_tx=1.
- An err_clr pulse then gives err_flags=0x0000.
REQ-038 ch_mask=0xFFFF with need_read=1:
- No rd_start pulses; exactly 1 + 32 + 2 + HOLD_CYC busy cycles; evt_tx increments by 1.
REQ-039 Preload evt_tx=0xFFFF by running 65535 events (or force in the bench), then run one event: evt_tx=0x0000.
REQ-040 Assert reset during WAIT on channel 7: all outputs are at reset values the next cycle, no trl_wr is issued, and evt_tx=0.
REQ-041 rd_done pulsed during HEADER, SCAN and HOLD is ignored; rd_done and timeout in the same WAIT cycle leave err_flags unchanged.
